// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings,
// the NOP word and the default sequential PC increment.
package fetch_unit_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FULL  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP             = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  // Redirect targets are word aligned; the low two bits are simply dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a one-entry skid buffer so a request already
// answered by memory is never lost when the decode stage stalls.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] pcOut,
  output logic [31:0] instOut,
  output logic        validOut
);

  //   state    | meaning
  //   ST_FETCH | request outstanding at pc_q, skid buffer empty
  //   ST_FULL  | no request, skid buffer holds the word fetched under stall

  localparam logic [31:0] STEP = 32'(PC_STEP);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  inst_out_q, inst_out_d;
  logic         valid_q, valid_d;
  logic [31:0]  skid_inst_q, skid_inst_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  pc_next;

  assign pc_next = pc_q + STEP;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    inst_out_d  = inst_out_q;
    valid_d     = valid_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (branchTaken) begin
      // Any word returned this cycle belongs to the wrong path and is dropped.
      state_d     = ST_FETCH;
      pc_d        = align_word(branchTarget);
      pc_out_d    = 32'h0000_0000;
      inst_out_d  = NOP;
      valid_d     = 1'b0;
      skid_inst_d = NOP;
      skid_pc_d   = 32'h0000_0000;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imemReady) begin
            pc_d = pc_next;
            if (stall && valid_q) begin
              skid_inst_d = imemData;
              skid_pc_d   = pc_next;
              state_d     = ST_FULL;
            end else begin
              inst_out_d = imemData;
              pc_out_d   = pc_next;
              valid_d    = 1'b1;
            end
          end else if (!stall) begin
            // Previous word was consumed and nothing new arrived.
            inst_out_d = NOP;
            valid_d    = 1'b0;
          end
        end
        ST_FULL: begin
          if (!stall) begin
            inst_out_d  = skid_inst_q;
            pc_out_d    = skid_pc_q;
            valid_d     = 1'b1;
            skid_inst_d = NOP;
            skid_pc_d   = 32'h0000_0000;
            state_d     = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      pc_out_q    <= 32'h0000_0000;
      inst_out_q  <= NOP;
      valid_q     <= 1'b0;
      skid_inst_q <= NOP;
      skid_pc_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_out_q    <= pc_out_d;
      inst_out_q  <= inst_out_d;
      valid_q     <= valid_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  // Request is suppressed for as long as reset is held.
  assign imemReq  = (state_q == ST_FETCH) && !rst;
  assign imemAddr = pc_q;
  assign pcOut    = pc_out_q;
  assign instOut  = inst_out_q;
  assign validOut = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/skid, branch flush,
// ready toggling, asynchronous reset in FULL and PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, imem_ready;
  logic [31:0] branch_target, imem_data;
  logic        imem_req;
  logic [31:0] imem_addr, pc_out, inst_out;
  logic        valid_out;

  logic        rst_w, stall_w, branch_taken_w, imem_ready_w;
  logic [31:0] branch_target_w, imem_data_w;
  logic        imem_req_w;
  logic [31:0] imem_addr_w, pc_out_w, inst_out_w;
  logic        valid_out_w;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branchTaken(branch_taken),
    .branchTarget(branch_target), .imemReq(imem_req), .imemAddr(imem_addr),
    .imemReady(imem_ready), .imemData(imem_data), .pcOut(pc_out),
    .instOut(inst_out), .validOut(valid_out)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .stall(stall_w), .branchTaken(branch_taken_w),
    .branchTarget(branch_target_w), .imemReq(imem_req_w), .imemAddr(imem_addr_w),
    .imemReady(imem_ready_w), .imemData(imem_data_w), .pcOut(pc_out_w),
    .instOut(inst_out_w), .validOut(valid_out_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst);
    check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    check({tag, ".pc"}, pc_out, pc);
    check({tag, ".inst"}, inst_out, inst);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
    branch_target = 32'h0; imem_data = 32'h0;
    rst_w = 1'b1; stall_w = 1'b0; branch_taken_w = 1'b0; imem_ready_w = 1'b1;
    branch_target_w = 32'h0; imem_data_w = 32'hBEEF_0001;

    #1;
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.addr", imem_addr, 32'h0);
    check_out("rst", 1'b0, 32'h0, 32'h0);
    step(); step();
    rst = 1'b0;
    #1;
    check("first.addr", imem_addr, 32'h0);
    check("first.req", {31'd0, imem_req}, 32'd1);

    // continuous streaming
    imem_ready = 1'b1; imem_data = 32'h1111_0000;
    step();
    check_out("s0", 1'b1, 32'h4, 32'h1111_0000);
    check("s0.addr", imem_addr, 32'h4);
    imem_data = 32'h1111_0004;
    step();
    check_out("s1", 1'b1, 32'h8, 32'h1111_0004);
    check("s1.addr", imem_addr, 32'h8);
    imem_data = 32'h1111_0008;
    step();
    check_out("s2", 1'b1, 32'hC, 32'h1111_0008);
    check("s2.addr", imem_addr, 32'hC);

    // stall three cycles; word at 0xC goes into the skid buffer
    stall = 1'b1; imem_data = 32'h1111_000C;
    step();
    check_out("st0", 1'b1, 32'hC, 32'h1111_0008);
    check("st0.req", {31'd0, imem_req}, 32'd0);
    check("st0.addr", imem_addr, 32'h10);
    imem_data = 32'hDEAD_DEAD;
    step();
    check_out("st1", 1'b1, 32'hC, 32'h1111_0008);
    check("st1.req", {31'd0, imem_req}, 32'd0);
    step();
    check_out("st2", 1'b1, 32'hC, 32'h1111_0008);
    stall = 1'b0;
    step();
    check_out("drain", 1'b1, 32'h10, 32'h1111_000C);
    check("drain.req", {31'd0, imem_req}, 32'd1);
    check("drain.addr", imem_addr, 32'h10);
    imem_data = 32'h1111_0010;
    step();
    check_out("after", 1'b1, 32'h14, 32'h1111_0010);

    // branch while FULL and stalled
    stall = 1'b1; imem_data = 32'h5555_0014;
    step();
    check("full2.req", {31'd0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h0000_0103; imem_data = 32'hBAD0_BAD0;
    step();
    check_out("br", 1'b0, 32'h0, 32'h0);
    check("br.addr", imem_addr, 32'h100);
    check("br.req", {31'd0, imem_req}, 32'd1);
    branch_taken = 1'b0; stall = 1'b0; imem_data = 32'h2222_0100;
    step();
    check_out("br.tgt", 1'b1, 32'h104, 32'h2222_0100);

    // imemReady toggling with no stall
    imem_ready = 1'b0;
    step();
    check("tg0.valid", {31'd0, valid_out}, 32'd0);
    check("tg0.inst", inst_out, 32'h0);
    imem_ready = 1'b1; imem_data = 32'h2222_0104;
    step();
    check_out("tg1", 1'b1, 32'h108, 32'h2222_0104);
    imem_ready = 1'b0;
    step();
    check("tg2.valid", {31'd0, valid_out}, 32'd0);
    check("tg2.inst", inst_out, 32'h0);
    imem_ready = 1'b1; imem_data = 32'h2222_0108;
    step();
    check_out("tg3", 1'b1, 32'h10C, 32'h2222_0108);
    imem_ready = 1'b0;
    step();
    check("tg4.valid", {31'd0, valid_out}, 32'd0);

    // not ready while stalled: outputs hold
    imem_ready = 1'b1; imem_data = 32'h2222_010C;
    step();
    check_out("h0", 1'b1, 32'h110, 32'h2222_010C);
    imem_ready = 1'b0; stall = 1'b1;
    step();
    check_out("h1", 1'b1, 32'h110, 32'h2222_010C);
    check("h1.req", {31'd0, imem_req}, 32'd1);

    // asynchronous reset while FULL
    imem_ready = 1'b1; imem_data = 32'h3333_0110;
    step();
    check("f3.req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    check_out("arst", 1'b0, 32'h0, 32'h0);
    check("arst.req", {31'd0, imem_req}, 32'd0);
    check("arst.addr", imem_addr, 32'h0);
    step();
    rst = 1'b0; stall = 1'b0;
    #1;
    check("post.addr", imem_addr, 32'h0);
    check("post.req", {31'd0, imem_req}, 32'd1);
    imem_data = 32'h4444_0000;
    step();
    check_out("post", 1'b1, 32'h4, 32'h4444_0000);

    // PC wrap on the second instance
    rst_w = 1'b0;
    #1;
    check("wrap.addr0", imem_addr_w, 32'hFFFF_FFFC);
    step();
    check("wrap.addr1", imem_addr_w, 32'h0);
    check("wrap.pc", pc_out_w, 32'h0);
    check("wrap.valid", {31'd0, valid_out_w}, 32'd1);
    check("wrap.inst", inst_out_w, 32'hBEEF_0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
